// File: rtl/execute_writeback_stage_pkg.sv
// Shared definitions for the 16-bit processor datapath: widths, opcode map, WB payload.
package proc_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NREGS      = 8;
    localparam int unsigned REG_AW     = 3;
    localparam int unsigned DMEM_DEPTH = 64;
    localparam int unsigned DMEM_AW    = 6;
    localparam int unsigned IMM_W      = 6;
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned SHAMT_W    = 4;

    // Opcode map; 10-15 are non-ALU and have no side effects in this stage.
    localparam logic [OPC_W-1:0] OPC_ADD   = 4'd0;
    localparam logic [OPC_W-1:0] OPC_SUB   = 4'd1;
    localparam logic [OPC_W-1:0] OPC_AND   = 4'd2;
    localparam logic [OPC_W-1:0] OPC_OR    = 4'd3;
    localparam logic [OPC_W-1:0] OPC_XOR   = 4'd4;
    localparam logic [OPC_W-1:0] OPC_SLL   = 4'd5;
    localparam logic [OPC_W-1:0] OPC_SRL   = 4'd6;
    localparam logic [OPC_W-1:0] OPC_PASS  = 4'd7;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 4'd8;
    localparam logic [OPC_W-1:0] OPC_STORE = 4'd9;

    // EX->WB pipeline register payload.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_t;

    // Zero-extend the immediate field to datapath width.
    function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

    // Opcodes whose result updates the zero/carry flags.
    function automatic logic sets_flags(input logic [OPC_W-1:0] opc);
        return (opc <= OPC_SRL);
    endfunction

endpackage : proc_pkg

// File: rtl/execute_writeback_stage_alu16.sv
// Combinational 16-bit ALU: arithmetic, logic, shifts and pass-through of op2.
module alu16
    import proc_pkg::*;
(
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    input  logic [OPC_W-1:0]  i_opcode,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_is_alu_op
);

    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_diff;
    logic [SHAMT_W-1:0] w_shamt;

    // Widened add/subtract so bit DATA_W carries the carry-out / borrow.
    always_comb begin
        w_sum   = {1'b0, i_op1} + {1'b0, i_op2};
        w_diff  = {1'b0, i_op1} - {1'b0, i_op2};
        w_shamt = i_op2[SHAMT_W-1:0];
    end

    // Operation select; non-ALU opcodes produce zero with no carry.
    always_comb begin
        o_result    = '0;
        o_carry     = 1'b0;
        o_is_alu_op = 1'b1;
        case (i_opcode)
            OPC_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OPC_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OPC_AND:  o_result = i_op1 & i_op2;
            OPC_OR:   o_result = i_op1 | i_op2;
            OPC_XOR:  o_result = i_op1 ^ i_op2;
            OPC_SLL:  o_result = i_op1 << w_shamt;
            OPC_SRL:  o_result = i_op1 >> w_shamt;
            OPC_PASS: o_result = i_op2;
            default:  o_is_alu_op = 1'b0;
        endcase
    end

endmodule : alu16

// File: rtl/execute_writeback_stage.sv
// Execute + writeback stage: register file, ALU, data memory, flags, EX->WB register
// and WB->EX forwarding so back-to-back dependent instructions never stall.
module execute_writeback_stage
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              instr_valid,
    input  logic              source2_select,
    input  logic              alu_out_select,
    input  logic              regwrite_flag,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [REG_AW-1:0] rreg_sig1,
    input  logic [REG_AW-1:0] rreg_sig2,
    input  logic [REG_AW-1:0] wreg_sig,
    input  logic [OPC_W-1:0]  opcode,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_wreg,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_flag,
    output logic              carry_flag
);

    logic [DATA_W-1:0]  r_rf   [NREGS];
    logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];
    wb_t                r_wb;
    logic               r_zero;
    logic               r_carry;

    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_rs2v;
    logic [DATA_W-1:0]  w_op2;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_carry;
    logic               w_is_alu_op;
    logic [DMEM_AW-1:0] w_mem_addr;
    logic [DATA_W-1:0]  w_load_data;
    logic [DATA_W-1:0]  w_ex_result;
    logic               w_store_en;
    logic               w_flag_en;

    // Operand fetch with WB forwarding; the in-flight write wins over the stale rf entry.
    always_comb begin
        w_op1  = r_rf[rreg_sig1];
        w_rs2v = r_rf[rreg_sig2];
        if (r_wb.we && (r_wb.wreg == rreg_sig1)) begin
            w_op1 = r_wb.data;
        end
        if (r_wb.we && (r_wb.wreg == rreg_sig2)) begin
            w_rs2v = r_wb.data;
        end
        w_op2 = source2_select ? zext_imm(immediate) : w_rs2v;
    end

    alu16 u_alu (
        .i_op1       (w_op1),
        .i_op2       (w_op2),
        .i_opcode    (opcode),
        .o_result    (w_alu_result),
        .o_carry     (w_alu_carry),
        .o_is_alu_op (w_is_alu_op)
    );

    // Memory address wraps naturally in the 6-bit sum; load read and result select.
    always_comb begin
        w_mem_addr  = w_op1[DMEM_AW-1:0] + DMEM_AW'(immediate);
        w_load_data = r_dmem[w_mem_addr];
        w_ex_result = alu_out_select ? w_load_data : w_alu_result;
        w_store_en  = instr_valid && (opcode == OPC_STORE) && !rstn;
        w_flag_en   = instr_valid && w_is_alu_op && sets_flags(opcode);
    end

    // Data memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            r_dmem[w_mem_addr] <= w_rs2v;
        end
    end

    // EX->WB pipeline register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wb <= '0;
        end else begin
            r_wb.valid <= instr_valid;
            r_wb.we    <= instr_valid && regwrite_flag;
            r_wb.wreg  <= wreg_sig;
            r_wb.data  <= w_ex_result;
        end
    end

    // Architectural register write from WB; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_wb.we) begin
            r_rf[r_wb.wreg] <= r_wb.data;
        end
    end

    // Zero/carry flags follow valid flag-setting ALU ops, otherwise hold.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_flag_en) begin
            r_zero  <= (w_alu_result == '0);
            r_carry <= w_alu_carry;
        end
    end

    // Output mapping.
    always_comb begin
        wb_valid   = r_wb.valid;
        wb_we      = r_wb.we;
        wb_wreg    = r_wb.wreg;
        wb_data    = r_wb.data;
        alu_result = w_alu_result;
        zero_flag  = r_zero;
        carry_flag = r_carry;
    end

endmodule : execute_writeback_stage

// File: tb/tb_execute_writeback_stage.sv
// Directed self-checking bench for execute_writeback_stage.
module tb_execute_writeback_stage;
    import proc_pkg::*;

    logic        clk;
    logic        rstn;
    logic        instr_valid;
    logic        source2_select;
    logic        alu_out_select;
    logic        regwrite_flag;
    logic [5:0]  immediate;
    logic [2:0]  rreg_sig1;
    logic [2:0]  rreg_sig2;
    logic [2:0]  wreg_sig;
    logic [3:0]  opcode;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_wreg;
    logic [15:0] wb_data;
    logic [15:0] alu_result;
    logic        zero_flag;
    logic        carry_flag;

    int n_cmp;
    int n_err;

    execute_writeback_stage dut (
        .clk            (clk),
        .rstn           (rstn),
        .instr_valid    (instr_valid),
        .source2_select (source2_select),
        .alu_out_select (alu_out_select),
        .regwrite_flag  (regwrite_flag),
        .immediate      (immediate),
        .rreg_sig1      (rreg_sig1),
        .rreg_sig2      (rreg_sig2),
        .wreg_sig       (wreg_sig),
        .opcode         (opcode),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_wreg        (wb_wreg),
        .wb_data        (wb_data),
        .alu_result     (alu_result),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic s2,
                         input logic [5:0] imm, input logic aos, input logic rw);
        instr_valid    = v;
        opcode         = op;
        wreg_sig       = rd;
        rreg_sig1      = rs1;
        rreg_sig2      = rs2;
        source2_select = s2;
        immediate      = imm;
        alu_out_select = aos;
        regwrite_flag  = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-writing ALU instruction, one clock.
    task automatic alu_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic s2, input logic [5:0] imm);
        drive(1'b1, op, rd, rs1, rs2, s2, imm, 1'b0, 1'b1);
        tick();
    endtask

    task automatic bubble();
        drive(1'b0, OPC_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
    endtask

    // Read a register through the combinational ALU (bubble ADD rX + 0), no clock edge.
    task automatic peek_reg(input string tag, input logic [2:0] r, input logic [15:0] exp);
        drive(1'b0, OPC_ADD, 3'd0, r, 3'd0, 1'b1, 6'd0, 1'b0, 1'b0);
        #1;
        check_eq(tag, {16'd0, alu_result}, {16'd0, exp});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b1;
        drive(1'b0, OPC_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wb_we",    {31'd0, wb_we}, 32'd0);
        check_eq("rst_wb_wreg",  {29'd0, wb_wreg}, 32'd0);
        check_eq("rst_wb_data",  {16'd0, wb_data}, 32'd0);
        check_eq("rst_zero",     {31'd0, zero_flag}, 32'd0);
        check_eq("rst_carry",    {31'd0, carry_flag}, 32'd0);
        check_eq("rst_alu",      {16'd0, alu_result}, 32'd0);
        rstn = 1'b0;

        // ADD R1 = R0 + 5
        alu_op(OPC_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 6'd5);
        check_eq("add_wb_data",  {16'd0, wb_data}, 32'd5);
        check_eq("add_wb_we",    {31'd0, wb_we}, 32'd1);
        check_eq("add_wb_wreg",  {29'd0, wb_wreg}, 32'd1);
        check_eq("add_zero",     {31'd0, zero_flag}, 32'd0);
        check_eq("add_carry",    {31'd0, carry_flag}, 32'd0);
        bubble();
        check_eq("bub_wb_we",    {31'd0, wb_we}, 32'd0);
        check_eq("bub_wb_valid", {31'd0, wb_valid}, 32'd0);
        peek_reg("r1_after_add", 3'd1, 16'd5);

        // Dependent pair: R2 = R0 + 9, then R3 = R2 + R2 via forwarding
        alu_op(OPC_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 6'd9);
        check_eq("dep1_wb_data", {16'd0, wb_data}, 32'd9);
        alu_op(OPC_ADD, 3'd3, 3'd2, 3'd2, 1'b0, 6'd0);
        check_eq("dep2_wb_data", {16'd0, wb_data}, 32'h12);
        bubble();
        peek_reg("r2_arch", 3'd2, 16'd9);
        peek_reg("r3_arch", 3'd3, 16'h12);

        // Borrow then carry-out to zero
        alu_op(OPC_SUB, 3'd1, 3'd0, 3'd0, 1'b1, 6'd1);
        check_eq("sub_wb_data",  {16'd0, wb_data}, 32'hFFFF);
        check_eq("sub_carry",    {31'd0, carry_flag}, 32'd1);
        check_eq("sub_zero",     {31'd0, zero_flag}, 32'd0);
        alu_op(OPC_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 6'd1);
        check_eq("wrap_wb_data", {16'd0, wb_data}, 32'd0);
        check_eq("wrap_zero",    {31'd0, zero_flag}, 32'd1);
        check_eq("wrap_carry",   {31'd0, carry_flag}, 32'd1);

        // Build R3 = 0x00AB: 0x15 << 3 = 0xA8, | 3 = 0xAB
        alu_op(OPC_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 6'h15);
        check_eq("bld_add",      {16'd0, wb_data}, 32'h15);
        alu_op(OPC_SLL, 3'd3, 3'd3, 3'd0, 1'b1, 6'd3);
        check_eq("bld_sll",      {16'd0, wb_data}, 32'hA8);
        check_eq("sll_carry",    {31'd0, carry_flag}, 32'd0);
        alu_op(OPC_OR,  3'd3, 3'd3, 3'd0, 1'b1, 6'd3);
        check_eq("bld_or",       {16'd0, wb_data}, 32'hAB);
        check_eq("or_zero",      {31'd0, zero_flag}, 32'd0);

        // STORE R3 at R0+63 (R3 forwarded from WB), then LOAD R4 from R0+63
        drive(1'b1, OPC_STORE, 3'd0, 3'd0, 3'd3, 1'b0, 6'd63, 1'b0, 1'b0);
        tick();
        check_eq("st_wb_we",     {31'd0, wb_we}, 32'd0);
        check_eq("st_wb_valid",  {31'd0, wb_valid}, 32'd1);
        drive(1'b1, OPC_LOAD, 3'd4, 3'd0, 3'd0, 1'b0, 6'd63, 1'b1, 1'b1);
        tick();
        check_eq("ld63_wb_data", {16'd0, wb_data}, 32'hAB);
        check_eq("ld63_wreg",    {29'd0, wb_wreg}, 32'd4);

        // R1 = 1; STORE R1 at R1+63 wraps to address 0; LOAD back both addresses
        alu_op(OPC_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 6'd1);
        drive(1'b1, OPC_STORE, 3'd0, 3'd1, 3'd1, 1'b0, 6'd63, 1'b0, 1'b0);
        tick();
        drive(1'b1, OPC_LOAD, 3'd5, 3'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b1);
        tick();
        check_eq("ld0_wrap",     {16'd0, wb_data}, 32'd1);
        drive(1'b1, OPC_LOAD, 3'd6, 3'd0, 3'd0, 1'b0, 6'd63, 1'b1, 1'b1);
        tick();
        check_eq("ld63_keep",    {16'd0, wb_data}, 32'hAB);

        // Bubble carrying SUB: combinational result visible, flags hold
        drive(1'b0, OPC_SUB, 3'd7, 3'd0, 3'd0, 1'b1, 6'd1, 1'b0, 1'b1);
        #1;
        check_eq("bub_alu_comb", {16'd0, alu_result}, 32'hFFFF);
        tick();
        check_eq("bub_carry",    {31'd0, carry_flag}, 32'd0);
        check_eq("bub_zero",     {31'd0, zero_flag}, 32'd0);
        check_eq("bub2_wb_we",   {31'd0, wb_we}, 32'd0);
        // Bubble carrying STORE to 63 must not write memory
        drive(1'b0, OPC_STORE, 3'd0, 3'd0, 3'd0, 1'b1, 6'd63, 1'b0, 1'b0);
        tick();
        drive(1'b1, OPC_LOAD, 3'd6, 3'd0, 3'd0, 1'b0, 6'd63, 1'b1, 1'b1);
        tick();
        check_eq("bub_no_store", {16'd0, wb_data}, 32'hAB);

        // STORE with regwrite set still writes the register
        drive(1'b1, OPC_STORE, 3'd7, 3'd0, 3'd3, 1'b0, 6'd10, 1'b0, 1'b1);
        tick();
        check_eq("st_rw_we",     {31'd0, wb_we}, 32'd1);
        check_eq("st_rw_wreg",   {29'd0, wb_wreg}, 32'd7);

        // Reset mid-flight: R6 = 0xFFFF (carry), R5 = R6 + 8, then reset with STORE presented
        alu_op(OPC_SUB, 3'd6, 3'd0, 3'd0, 1'b1, 6'd1);
        check_eq("pre_carry",    {31'd0, carry_flag}, 32'd1);
        alu_op(OPC_ADD, 3'd5, 3'd6, 3'd0, 1'b1, 6'd8);
        check_eq("pre_r5_data",  {16'd0, wb_data}, 32'd7);
        check_eq("pre_r5_carry", {31'd0, carry_flag}, 32'd1);
        rstn = 1'b1;
        drive(1'b1, OPC_STORE, 3'd0, 3'd0, 3'd6, 1'b0, 6'd63, 1'b0, 1'b0);
        tick();
        rstn = 1'b0;
        check_eq("mrst_valid",   {31'd0, wb_valid}, 32'd0);
        check_eq("mrst_we",      {31'd0, wb_we}, 32'd0);
        check_eq("mrst_data",    {16'd0, wb_data}, 32'd0);
        check_eq("mrst_carry",   {31'd0, carry_flag}, 32'd0);
        check_eq("mrst_zero",    {31'd0, zero_flag}, 32'd0);
        peek_reg("mrst_r5", 3'd5, 16'd0);
        peek_reg("mrst_r6", 3'd6, 16'd0);
        drive(1'b1, OPC_LOAD, 3'd4, 3'd0, 3'd0, 1'b0, 6'd63, 1'b1, 1'b1);
        tick();
        check_eq("mrst_no_store", {16'd0, wb_data}, 32'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_execute_writeback_stage
